// File: rtl/hazard_control.sv
// Load-use / memory-wait / redirect hazard controller for the 5-stage core.
// Control outputs are combinational; counters and the timeout flag are registered.
module hazard_control #(
    parameter int COUNTER_WIDTH      = 32,
    parameter int MEM_TIMEOUT_CYCLES = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fetchDecodeValid,
    input  logic [4:0]               fetchDecodeRegister1,
    input  logic [4:0]               fetchDecodeRegister2,
    input  logic                     fetchDecodeUsesRegister1,
    input  logic                     fetchDecodeUsesRegister2,
    input  logic                     decodeExecuteValid,
    input  logic                     decodeExecuteIsLoad,
    input  logic [4:0]               decodeExecuteDestinationRegister,
    input  logic                     executeRedirect,
    input  logic                     trapRedirect,
    input  logic                     memoryRequest,
    input  logic                     memoryReady,
    output logic                     stallFetch,
    output logic                     stallDecode,
    output logic                     stallExecute,
    output logic                     stallMemory,
    output logic                     bubbleExecute,
    output logic                     flushDecode,
    output logic                     flushExecute,
    output logic                     flushMemory,
    output logic [COUNTER_WIDTH-1:0] loadUseStallCount,
    output logic [COUNTER_WIDTH-1:0] memoryWaitCount,
    output logic                     memTimeout
);

    // state     | meaning
    // RUN       | normal flow, hazards resolved by priority
    // MEM_WAIT  | data memory has not acknowledged, whole pipe frozen
    // DRAIN     | trap taken during a wait, discard the orphaned response
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_DRAIN    = 2'b10
    } state_e;

    localparam int WD_W = $clog2(MEM_TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(MEM_TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    state_e                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] lu_cnt_q, lu_cnt_d;
    logic [COUNTER_WIDTH-1:0] mw_cnt_q, mw_cnt_d;
    logic [WD_W-1:0]          wd_cnt_q, wd_cnt_d;
    logic                     timeout_q, timeout_d;

    logic load_use;
    logic mem_wait;
    logic wait_cycle;
    logic stall_fetch_c, stall_decode_c, stall_execute_c, stall_memory_c;
    logic bubble_c, flush_decode_c, flush_execute_c, flush_memory_c;

    assign load_use = fetchDecodeValid & decodeExecuteValid & decodeExecuteIsLoad &
                      (decodeExecuteDestinationRegister != 5'd0) &
                      ((fetchDecodeUsesRegister1 &
                        (fetchDecodeRegister1 == decodeExecuteDestinationRegister)) |
                       (fetchDecodeUsesRegister2 &
                        (fetchDecodeRegister2 == decodeExecuteDestinationRegister)));

    assign mem_wait = memoryRequest & ~memoryReady;

    // The cycle that enters MEM_WAIT/DRAIN is already a wait cycle.
    assign wait_cycle = ~memoryReady & ((state_q != ST_RUN) | mem_wait);

    always_comb begin
        state_d         = state_q;
        stall_fetch_c   = 1'b0;
        stall_decode_c  = 1'b0;
        stall_execute_c = 1'b0;
        stall_memory_c  = 1'b0;
        bubble_c        = 1'b0;
        flush_decode_c  = 1'b0;
        flush_execute_c = 1'b0;
        flush_memory_c  = 1'b0;
        case (state_q)
            ST_DRAIN: begin
                stall_fetch_c   = 1'b1;
                flush_decode_c  = 1'b1;
                flush_execute_c = 1'b1;
                flush_memory_c  = 1'b1;
                if (!trapRedirect && memoryReady) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (trapRedirect) begin
                    flush_decode_c  = 1'b1;
                    flush_execute_c = 1'b1;
                    flush_memory_c  = 1'b1;
                    state_d         = mem_wait ? ST_DRAIN : ST_RUN;
                end else if (mem_wait) begin
                    stall_fetch_c   = 1'b1;
                    stall_decode_c  = 1'b1;
                    stall_execute_c = 1'b1;
                    stall_memory_c  = 1'b1;
                    state_d         = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                    if (executeRedirect) begin
                        flush_decode_c  = 1'b1;
                        flush_execute_c = 1'b1;
                    end else if (load_use) begin
                        stall_fetch_c  = 1'b1;
                        stall_decode_c = 1'b1;
                        bubble_c       = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        lu_cnt_d  = lu_cnt_q;
        mw_cnt_d  = mw_cnt_q;
        wd_cnt_d  = WD_LOAD;
        timeout_d = timeout_q;
        if (bubble_c && (lu_cnt_q != CNT_MAX)) begin
            lu_cnt_d = lu_cnt_q + CNT_ONE;
        end
        if (wait_cycle && (mw_cnt_q != CNT_MAX)) begin
            mw_cnt_d = mw_cnt_q + CNT_ONE;
        end
        // Watchdog: down-counter reloaded on any non-wait cycle.
        if (wait_cycle) begin
            wd_cnt_d = (wd_cnt_q != '0) ? (wd_cnt_q - WD_ONE) : wd_cnt_q;
            if (wd_cnt_q == WD_ONE) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            lu_cnt_q  <= '0;
            mw_cnt_q  <= '0;
            wd_cnt_q  <= WD_LOAD;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lu_cnt_q  <= lu_cnt_d;
            mw_cnt_q  <= mw_cnt_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign stallFetch        = stall_fetch_c   & ~reset;
    assign stallDecode       = stall_decode_c  & ~reset;
    assign stallExecute      = stall_execute_c & ~reset;
    assign stallMemory       = stall_memory_c  & ~reset;
    assign bubbleExecute     = bubble_c        & ~reset;
    assign flushDecode       = flush_decode_c  & ~reset;
    assign flushExecute      = flush_execute_c & ~reset;
    assign flushMemory       = flush_memory_c  & ~reset;
    assign loadUseStallCount = lu_cnt_q;
    assign memoryWaitCount   = mw_cnt_q;
    assign memTimeout        = timeout_q;

endmodule
